// File: rtl/ctrl_contexto_pkg.sv
// ctrl_contexto_pkg -- controller states, frame geometry and user-mode limit. Rev 1.0
`default_nettype none

package ctrl_contexto_pkg;

  localparam int          NUM_REGS   = 8;
  localparam logic [31:0] FRAME_SIZE = 32'd9;
  localparam logic [31:0] FRAME_BASE = 32'd28;
  localparam logic [31:0] SO_LIMIT   = 32'd687;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_PC  = 3'd1,
    SAVE_REG = 3'd2,
    LOAD_PC  = 3'd3,
    LOAD_REG = 3'd4,
    DONE     = 3'd5
  } estado_t;

  function automatic logic [31:0] frame_base(input logic [1:0] pid);
    return FRAME_BASE + {30'd0, pid} * FRAME_SIZE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_contexto_mux.sv
// mux_memoria -- routes either the CPU or the context controller onto the data memory port. Rev 1.0
`default_nettype none

module mux_memoria (
  input  logic        sel_ctrl_i,
  input  logic        cpu_write_i,
  input  logic [31:0] cpu_posicao_i,
  input  logic [31:0] cpu_dados_i,
  input  logic        ctrl_write_i,
  input  logic [31:0] ctrl_posicao_i,
  input  logic [31:0] ctrl_dados_i,
  output logic        mem_write_o,
  output logic [31:0] mem_posicao_o,
  output logic [31:0] mem_dados_o
);

  assign mem_write_o   = sel_ctrl_i ? ctrl_write_i   : cpu_write_i;
  assign mem_posicao_o = sel_ctrl_i ? ctrl_posicao_i : cpu_posicao_i;
  assign mem_dados_o   = sel_ctrl_i ? ctrl_dados_i   : cpu_dados_i;

endmodule

`default_nettype wire

// File: rtl/ctrl_contexto.sv
// ctrl_contexto -- saves/restores PC plus register file to per-process frames in data memory. Rev 1.0
`default_nettype none

module ctrl_contexto
  import ctrl_contexto_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_memWrite,
  input  logic        cpu_memRead,
  input  logic [31:0] cpu_posicao,
  input  logic [31:0] cpu_dados,
  output logic [31:0] cpu_saida,
  input  logic        salvar,
  input  logic        restaurar,
  input  logic        fim_prog,
  input  logic [1:0]  proc_id,
  input  logic [31:0] pos_atual,
  input  logic [31:0] end_atual,
  output logic [4:0]  reg_idx,
  input  logic [31:0] reg_dado,
  output logic        reg_we,
  output logic [31:0] reg_wdado,
  output logic        mem_write,
  output logic [31:0] mem_posicao,
  output logic [31:0] mem_dados,
  input  logic [31:0] mem_saida,
  output logic        stall,
  output logic [31:0] pc_restaurado,
  output logic        pc_valido,
  output logic        done
);

  estado_t     estado_q, estado_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_rest_q, pc_rest_d;
  logic        pc_valido_q, pc_valido_d;

  logic        sel_ctrl;
  logic        ctrl_write;
  logic [31:0] ctrl_posicao;
  logic [31:0] ctrl_dados;
  logic        save_ok;
  logic        ultimo;
  logic        unused_memread;

  // The read strobe carries no information for a combinational-read memory.
  assign unused_memread = cpu_memRead;

  // fim_prog saves regardless of where the PC currently is.
  assign save_ok = (salvar | fim_prog) & ((pos_atual > SO_LIMIT) | fim_prog);
  assign ultimo  = (cnt_q == 5'(NUM_REGS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      pc_q        <= '0;
      pc_rest_q   <= '0;
      pc_valido_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      pc_q        <= pc_d;
      pc_rest_q   <= pc_rest_d;
      pc_valido_q <= pc_valido_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    pc_d         = pc_q;
    pc_rest_d    = pc_rest_q;
    pc_valido_d  = pc_valido_q;
    sel_ctrl     = 1'b1;
    ctrl_write   = 1'b0;
    ctrl_posicao = base_q;
    ctrl_dados   = '0;
    reg_we       = 1'b0;
    reg_wdado    = '0;
    case (estado_q)
      IDLE: begin
        sel_ctrl = 1'b0;
        if (save_ok) begin
          estado_d    = SAVE_PC;
          base_d      = frame_base(proc_id);
          pc_d        = end_atual;
          cnt_d       = '0;
          pc_valido_d = 1'b0;
        end else if (restaurar) begin
          estado_d = LOAD_PC;
          base_d   = frame_base(proc_id);
          cnt_d    = '0;
        end
      end
      SAVE_PC: begin
        ctrl_write = 1'b1;
        ctrl_dados = pc_q;
        estado_d   = SAVE_REG;
      end
      SAVE_REG: begin
        ctrl_write   = 1'b1;
        ctrl_posicao = base_q + 32'd1 + {27'd0, cnt_q};
        ctrl_dados   = reg_dado;
        cnt_d        = cnt_q + 5'd1;
        if (ultimo) estado_d = DONE;
      end
      LOAD_PC: begin
        pc_rest_d = mem_saida;
        estado_d  = LOAD_REG;
      end
      LOAD_REG: begin
        ctrl_posicao = base_q + 32'd1 + {27'd0, cnt_q};
        reg_we       = 1'b1;
        reg_wdado    = mem_saida;
        cnt_d        = cnt_q + 5'd1;
        if (ultimo) begin
          estado_d    = DONE;
          pc_valido_d = 1'b1;
        end
      end
      DONE:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  mux_memoria u_mux (
    .sel_ctrl_i     (sel_ctrl),
    .cpu_write_i    (cpu_memWrite),
    .cpu_posicao_i  (cpu_posicao),
    .cpu_dados_i    (cpu_dados),
    .ctrl_write_i   (ctrl_write),
    .ctrl_posicao_i (ctrl_posicao),
    .ctrl_dados_i   (ctrl_dados),
    .mem_write_o    (mem_write),
    .mem_posicao_o  (mem_posicao),
    .mem_dados_o    (mem_dados)
  );

  assign cpu_saida     = mem_saida;
  assign reg_idx       = cnt_q;
  assign stall         = (estado_q != IDLE);
  assign done          = (estado_q == DONE);
  assign pc_restaurado = pc_rest_q;
  assign pc_valido     = pc_valido_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_contexto.sv
// tb_ctrl_contexto -- directed and randomized checks of ctrl_contexto against a frame-level model. Rev 1.0
`default_nettype none

module tb_ctrl_contexto;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memWrite, cpu_memRead;
  logic [31:0] cpu_posicao, cpu_dados, cpu_saida;
  logic        salvar, restaurar, fim_prog;
  logic [1:0]  proc_id;
  logic [31:0] pos_atual, end_atual;
  logic [4:0]  reg_idx;
  logic [31:0] reg_dado;
  logic        reg_we;
  logic [31:0] reg_wdado;
  logic        mem_write;
  logic [31:0] mem_posicao, mem_dados, mem_saida;
  logic        stall;
  logic [31:0] pc_restaurado;
  logic        pc_valido, done;

  // Environment: data memory and register file seen by the DUT.
  logic [31:0] mem [64];
  logic [31:0] rf  [32];
  logic        mem_init, rf_load;
  logic [31:0] rf_new [8];

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [31:0] m_rf [8];
  logic [31:0] m_pc;
  logic        m_valid;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign mem_saida = (mem_posicao < 32'd64) ? mem[mem_posicao[5:0]] : 32'h0;
  assign reg_dado  = rf[reg_idx];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hDEAD0000 | i;
    end else if (mem_write && mem_posicao < 32'd64) begin
      mem[mem_posicao[5:0]] <= mem_dados;
    end
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_new[i];
    end else if (reg_we) begin
      rf[reg_idx] <= reg_wdado;
    end
  end

  ctrl_contexto dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memWrite  (cpu_memWrite),
    .cpu_memRead   (cpu_memRead),
    .cpu_posicao   (cpu_posicao),
    .cpu_dados     (cpu_dados),
    .cpu_saida     (cpu_saida),
    .salvar        (salvar),
    .restaurar     (restaurar),
    .fim_prog      (fim_prog),
    .proc_id       (proc_id),
    .pos_atual     (pos_atual),
    .end_atual     (end_atual),
    .reg_idx       (reg_idx),
    .reg_dado      (reg_dado),
    .reg_we        (reg_we),
    .reg_wdado     (reg_wdado),
    .mem_write     (mem_write),
    .mem_posicao   (mem_posicao),
    .mem_dados     (mem_dados),
    .mem_saida     (mem_saida),
    .stall         (stall),
    .pc_restaurado (pc_restaurado),
    .pc_valido     (pc_valido),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int fbase(input logic [1:0] pid);
    return 28 + 9 * int'(pid);
  endfunction

  task automatic load_regs(input bit rnd, input logic [31:0] first);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rf_new[i] = rnd ? $urandom : first + i;
      m_rf[i]   = rf_new[i];
    end
    rf_load = 1'b1;
    @(posedge clk);
    #1 rf_load = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 64; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], ref_mem[i]);
    for (int i = 0; i < 8; i++)  chk($sformatf("%s r%0d", tag, i), rf[i], m_rf[i]);
    chk({tag, " pc_restaurado"}, pc_restaurado, m_pc);
    chk({tag, " pc_valido"}, {31'd0, pc_valido}, {31'd0, m_valid});
  endtask

  // One request presented in IDLE; the model decides from the rules whether it runs.
  task automatic op(input string tag, input logic sv, input logic rs, input logic fp,
                    input logic [1:0] pid, input logic [31:0] pos, input logic [31:0] pc);
    bit is_save, is_rest;
    int b;
    is_save = (sv || fp) && (pos > 687 || fp);
    is_rest = !is_save && rs;
    b = fbase(pid);
    @(negedge clk);
    salvar = sv; restaurar = rs; fim_prog = fp;
    proc_id = pid; pos_atual = pos; end_atual = pc;
    #1 chk({tag, " idle stall"}, {31'd0, stall}, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((is_save || is_rest) && c == 1) begin
        salvar = 1'b0; restaurar = 1'b0; fim_prog = 1'b0;
        cpu_memWrite = 1'b1; cpu_posicao = 32'd3; cpu_dados = $urandom;
      end
      #1;
      if (is_save || is_rest) begin
        chk($sformatf("%s stall c%0d", tag, c), {31'd0, stall}, 32'd1);
        chk($sformatf("%s done c%0d", tag, c), {31'd0, done}, {31'd0, c == 10});
        if (c == 1 && is_save) begin
          chk({tag, " pc addr"}, mem_posicao, b);
          chk({tag, " pc data"}, mem_dados, pc);
        end
        if (c <= 9)
          chk($sformatf("%s mem_write c%0d", tag, c), {31'd0, mem_write}, {31'd0, is_save});
        if (c == 10) begin
          cpu_memWrite = 1'b0;
          break;
        end
      end else begin
        chk($sformatf("%s ign stall c%0d", tag, c), {31'd0, stall}, 32'd0);
        chk($sformatf("%s ign done c%0d", tag, c), {31'd0, done}, 32'd0);
      end
    end
    salvar = 1'b0; restaurar = 1'b0; fim_prog = 1'b0;
    if (is_save) begin
      ref_mem[b] = pc;
      for (int i = 0; i < 8; i++) ref_mem[b + 1 + i] = m_rf[i];
      m_valid = 1'b0;
    end else if (is_rest) begin
      m_pc = ref_mem[b];
      for (int i = 0; i < 8; i++) m_rf[i] = ref_mem[b + 1 + i];
      m_valid = 1'b1;
    end
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; rf_load = 1'b1;
    cpu_memWrite = 1'b0; cpu_memRead = 1'b0; cpu_posicao = '0; cpu_dados = '0;
    salvar = 1'b0; restaurar = 1'b0; fim_prog = 1'b0; proc_id = '0;
    pos_atual = '0; end_atual = '0;
    for (int i = 0; i < 8; i++) begin rf_new[i] = '0; m_rf[i] = '0; end
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hDEAD0000 | i;
    m_pc = '0; m_valid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst pc_valido", {31'd0, pc_valido}, 32'd0);
    chk("rst pc_restaurado", pc_restaurado, 32'd0);
    chk("rst mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0; rf_load = 1'b0;

    // Passthrough in IDLE
    @(negedge clk);
    cpu_memWrite = 1'b1; cpu_posicao = 32'd5; cpu_dados = 32'hAA;
    #1;
    chk("pt mem_write", {31'd0, mem_write}, 32'd1);
    chk("pt addr", mem_posicao, 32'd5);
    chk("pt data", mem_dados, 32'hAA);
    chk("pt stall", {31'd0, stall}, 32'd0);
    chk("pt cpu_saida old", cpu_saida, ref_mem[5]);
    @(negedge clk);
    ref_mem[5] = 32'hAA;
    cpu_memWrite = 1'b0;
    #1 chk("pt cpu_saida new", cpu_saida, 32'hAA);

    // Save proc 1, OS guard, fim_prog override
    load_regs(1'b0, 32'h10);
    op("save p1", 1'b1, 1'b0, 1'b0, 2'd1, 32'd700, 32'h2C4);
    op("os guard", 1'b1, 1'b0, 1'b0, 2'd2, 32'd600, 32'h111);
    op("os edge", 1'b1, 1'b0, 1'b0, 2'd2, 32'd687, 32'h112);
    op("fim_prog", 1'b0, 1'b0, 1'b1, 2'd2, 32'd600, 32'h123);

    // Restore proc 1 over scrambled registers
    load_regs(1'b1, 32'h0);
    op("rest p1", 1'b0, 1'b1, 1'b0, 2'd1, 32'd0, 32'h0);

    // Save wins over restore; first user address
    op("both", 1'b1, 1'b1, 1'b0, 2'd0, 32'd700, 32'h55);
    load_regs(1'b1, 32'h0);
    op("pos688", 1'b1, 1'b0, 1'b0, 2'd3, 32'd688, 32'h777);

    // Randomized operation mix
    for (int k = 0; k < 12; k++) begin
      int kind;
      logic [1:0] pid;
      kind = $urandom_range(0, 3);
      pid  = 2'($urandom_range(0, 3));
      case (kind)
        0: begin
          load_regs(1'b1, 32'h0);
          op($sformatf("rnd%0d save", k), 1'b1, 1'($urandom_range(0, 1)), 1'b0, pid,
             $urandom_range(688, 5000), $urandom);
        end
        1: begin
          load_regs(1'b1, 32'h0);
          op($sformatf("rnd%0d fim", k), 1'($urandom_range(0, 1)), 1'b0, 1'b1, pid,
             $urandom_range(0, 5000), $urandom);
        end
        2: op($sformatf("rnd%0d ign", k), 1'b1, 1'b0, 1'b0, pid,
              $urandom_range(0, 687), $urandom);
        default: op($sformatf("rnd%0d rest", k), 1'b0, 1'b1, 1'b0, pid, 32'd0, 32'h0);
      endcase
    end

    // Reset while SAVE_REG has cnt=3
    load_regs(1'b1, 32'h0);
    @(negedge clk);
    salvar = 1'b1; proc_id = 2'd3; pos_atual = 32'd900; end_atual = 32'hABC;
    @(negedge clk);
    salvar = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst stall", {31'd0, stall}, 32'd0);
    chk("mid rst done", {31'd0, done}, 32'd0);
    chk("mid rst reg_we", {31'd0, reg_we}, 32'd0);
    chk("mid rst mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[55] = 32'hABC;
    for (int i = 0; i < 3; i++) ref_mem[56 + i] = m_rf[i];
    m_valid = 1'b0;
    m_pc = 32'd0;
    check_state("mid rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
